// File: rtl/branch_predictor.sv
// Dynamic branch predictor: PC-indexed table of 2-bit saturating counters,
// E-stage resolution against ALU flags, and saturating branch/mispredict statistics.
module branch_predictor #(
    parameter int ENTRIES     = 16,
    parameter int XLEN        = 32,
    parameter int STAT_W      = 16,
    parameter int STATIC_MODE = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              branch_D,
    input  logic              jump_D,
    input  logic [2:0]        funct3_D,
    input  logic [XLEN-1:0]   pc_D,
    input  logic              stall_E,
    input  logic              flush_E,
    input  logic              N,
    input  logic              Z,
    input  logic              C,
    output logic [1:0]        PCSrcE,
    output logic              predict_taken_D,
    output logic              mispredict_E,
    output logic [STAT_W-1:0] branch_count,
    output logic [STAT_W-1:0] mispredict_count
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam bit FORCE_TAKEN = (STATIC_MODE != 0);

    logic [1:0]       ctr [ENTRIES];
    logic [IDX_W-1:0] idx_D;
    logic             valid_E;
    logic [2:0]       funct3_E;
    logic [IDX_W-1:0] idx_E;
    logic             pred_E;
    logic             taken_E;
    logic             unused_pc;

    assign idx_D     = pc_D[IDX_W+1:2];
    assign unused_pc = ^{pc_D[XLEN-1:IDX_W+2], pc_D[1:0]};

    // Lookup reads the registered table, so a same-cycle update is not bypassed.
    assign predict_taken_D = branch_D & (FORCE_TAKEN | ctr[idx_D][1]);

    always_comb begin
        taken_E = 1'b0;
        case (funct3_E)
            3'b000:  taken_E = Z;
            3'b001:  taken_E = ~Z;
            3'b100:  taken_E = N;
            3'b101:  taken_E = ~N;
            3'b110:  taken_E = C;
            3'b111:  taken_E = ~C;
            default: taken_E = 1'b0;
        endcase
    end

    assign mispredict_E = valid_E & (taken_E != pred_E);

    always_comb begin
        PCSrcE = 2'b00;
        if (mispredict_E)
            PCSrcE = pred_E ? 2'b10 : 2'b11;
        else if (predict_taken_D | jump_D)
            PCSrcE = 2'b01;
    end

    // D->E register: flush wins over stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_E  <= 1'b0;
            funct3_E <= 3'b000;
            idx_E    <= '0;
            pred_E   <= 1'b0;
        end else if (flush_E) begin
            valid_E <= 1'b0;
        end else if (!stall_E) begin
            valid_E  <= branch_D;
            funct3_E <= funct3_D;
            idx_E    <= idx_D;
            pred_E   <= predict_taken_D;
        end
    end

    // Training and statistics fire once, on the edge where the E branch leaves.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++)
                ctr[i] <= 2'b01;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (valid_E && !stall_E) begin
            if (taken_E && ctr[idx_E] != 2'b11)
                ctr[idx_E] <= ctr[idx_E] + 2'b01;
            else if (!taken_E && ctr[idx_E] != 2'b00)
                ctr[idx_E] <= ctr[idx_E] - 2'b01;
            if (branch_count != {STAT_W{1'b1}})
                branch_count <= branch_count + STAT_W'(1);
            if (mispredict_E && mispredict_count != {STAT_W{1'b1}})
                mispredict_count <= mispredict_count + STAT_W'(1);
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: three instances (default, 2-bit statistics, static-taken)
// share one stimulus stream and are compared every cycle against a table/integer model.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        branch_D, jump_D, stall_E, flush_E, N, Z, C;
    logic [2:0]  funct3_D;
    logic [31:0] pc_D;

    logic [1:0]  src_m, src_2, src_s;
    logic        pred_m, pred_2, pred_s, misp_m, misp_2, misp_s;
    logic [15:0] bc_m, mc_m, bc_s, mc_s;
    logic [1:0]  bc_2, mc_2;

    int checks = 0;
    int passed = 0;
    int step_no = 0;

    // Reference model: counter values as plain ints, counts as saturating ints.
    int  mtab [16];
    bit  m_valid, m_pred, m_pred_s;
    bit  [2:0] m_f3;
    int  m_idx;
    int  bc, mc, bc2, mc2, mcs;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(16), .XLEN(32), .STAT_W(16), .STATIC_MODE(0)) u_dut (
        .clk(clk), .reset_n(reset_n), .branch_D(branch_D), .jump_D(jump_D),
        .funct3_D(funct3_D), .pc_D(pc_D), .stall_E(stall_E), .flush_E(flush_E),
        .N(N), .Z(Z), .C(C), .PCSrcE(src_m), .predict_taken_D(pred_m),
        .mispredict_E(misp_m), .branch_count(bc_m), .mispredict_count(mc_m));

    branch_predictor #(.ENTRIES(16), .XLEN(32), .STAT_W(2), .STATIC_MODE(0)) u_sat (
        .clk(clk), .reset_n(reset_n), .branch_D(branch_D), .jump_D(jump_D),
        .funct3_D(funct3_D), .pc_D(pc_D), .stall_E(stall_E), .flush_E(flush_E),
        .N(N), .Z(Z), .C(C), .PCSrcE(src_2), .predict_taken_D(pred_2),
        .mispredict_E(misp_2), .branch_count(bc_2), .mispredict_count(mc_2));

    branch_predictor #(.ENTRIES(16), .XLEN(32), .STAT_W(16), .STATIC_MODE(1)) u_static (
        .clk(clk), .reset_n(reset_n), .branch_D(branch_D), .jump_D(jump_D),
        .funct3_D(funct3_D), .pc_D(pc_D), .stall_E(stall_E), .flush_E(flush_E),
        .N(N), .Z(Z), .C(C), .PCSrcE(src_s), .predict_taken_D(pred_s),
        .mispredict_E(misp_s), .branch_count(bc_s), .mispredict_count(mc_s));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp);
    endtask

    function automatic bit cond(input bit [2:0] f3, input bit n, input bit z, input bit c);
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return n;
            3'd5: return !n;
            3'd6: return c;
            3'd7: return !c;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_reset();
        foreach (mtab[i]) mtab[i] = 1;
        m_valid = 0; m_pred = 0; m_pred_s = 0; m_f3 = 0; m_idx = 0;
        bc = 0; mc = 0; bc2 = 0; mc2 = 0; mcs = 0;
    endtask

    task automatic check_counts();
        chk("branch_count", 32'(bc_m), 32'(bc));
        chk("mispredict_count", 32'(mc_m), 32'(mc));
        chk("branch_count_w2", 32'(bc_2), 32'(bc2));
        chk("mispredict_count_w2", 32'(mc_2), 32'(mc2));
        chk("branch_count_static", 32'(bc_s), 32'(bc));
        chk("mispredict_count_static", 32'(mc_s), 32'(mcs));
    endtask

    // Async reset asserted mid-cycle; D inputs idle so PCSrcE must read 00.
    task automatic do_reset();
        branch_D = 0; jump_D = 0; funct3_D = 0; pc_D = 0;
        stall_E = 0; flush_E = 0; N = 0; Z = 0; C = 0;
        #2 reset_n = 1'b0;
        #1 model_reset();
        step_no++;
        chk("reset_pcsrc", 32'(src_m), 0);
        chk("reset_mispredict", 32'(misp_m), 0);
        chk("reset_mispredict_static", 32'(misp_s), 0);
        check_counts();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One cycle: drive at negedge, compare combinational outputs, advance model past the edge.
    task automatic step(input bit br, input bit jp, input bit [2:0] f3, input logic [31:0] pc,
                        input bit st, input bit fl, input bit n, input bit z, input bit c);
        int  idx;
        bit  pd, pds, tk, ms, mss;
        int  es, ess;
        branch_D = br; jump_D = jp; funct3_D = f3; pc_D = pc;
        stall_E = st; flush_E = fl; N = n; Z = z; C = c;
        #1;
        step_no++;
        idx = int'((pc >> 2) % 16);
        pd  = br && (mtab[idx] >= 2);
        pds = br;
        tk  = cond(m_f3, n, z, c);
        ms  = m_valid && (tk != m_pred);
        mss = m_valid && (tk != m_pred_s);
        es  = ms  ? (m_pred   ? 2 : 3) : ((pd  || jp) ? 1 : 0);
        ess = mss ? (m_pred_s ? 2 : 3) : ((pds || jp) ? 1 : 0);
        chk("predict", 32'(pred_m), 32'(pd));
        chk("predict_w2", 32'(pred_2), 32'(pd));
        chk("predict_static", 32'(pred_s), 32'(pds));
        chk("mispredict", 32'(misp_m), 32'(ms));
        chk("mispredict_w2", 32'(misp_2), 32'(ms));
        chk("mispredict_static", 32'(misp_s), 32'(mss));
        chk("pcsrc", 32'(src_m), 32'(es));
        chk("pcsrc_w2", 32'(src_2), 32'(es));
        chk("pcsrc_static", 32'(src_s), 32'(ess));
        check_counts();
        if (m_valid && !st) begin
            mtab[m_idx] = tk ? sat(mtab[m_idx] + 1, 3) : ((mtab[m_idx] > 0) ? mtab[m_idx] - 1 : 0);
            bc  = sat(bc + 1, 65535);
            bc2 = sat(bc2 + 1, 3);
            if (ms) begin
                mc  = sat(mc + 1, 65535);
                mc2 = sat(mc2 + 1, 3);
            end
            if (mss) mcs = sat(mcs + 1, 65535);
        end
        if (fl) m_valid = 0;
        else if (!st) begin
            m_valid = br; m_f3 = f3; m_idx = idx; m_pred = pd; m_pred_s = pds;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
        do_reset();

        // Fresh counter 01: not taken, PCSrcE 00.
        step(1, 0, 3'd0, 32'h40, 0, 0, 0, 0, 0);
        // BEQ resolves taken against NT prediction -> PCSrcE 11, counter to 10.
        step(0, 0, 3'd0, 32'h0, 0, 0, 0, 1, 0);
        // Now predicted taken; three taken resolutions saturate the counter.
        step(1, 0, 3'd0, 32'h40, 0, 0, 0, 0, 0);
        step(1, 0, 3'd0, 32'h40, 0, 0, 0, 1, 0);
        step(1, 0, 3'd0, 32'h40, 0, 0, 0, 1, 0);
        step(1, 0, 3'd0, 32'h40, 0, 0, 0, 1, 0);
        // Not-taken resolution with a JAL in Decode: recover to pc_E+4 wins.
        step(1, 1, 3'd0, 32'h40, 0, 0, 0, 0, 0);
        step(1, 0, 3'd0, 32'h40, 0, 0, 0, 1, 0);

        // BLTU / BGEU / funct3=010 with C=1, then drain.
        step(1, 0, 3'd6, 32'h80, 0, 0, 0, 1, 0);
        step(1, 0, 3'd7, 32'h84, 0, 0, 1, 1, 1);
        step(1, 0, 3'd2, 32'h88, 0, 0, 1, 1, 1);
        step(0, 0, 3'd0, 32'h0,  0, 0, 1, 1, 1);

        // Branch held in E by stall for three cycles, then released once.
        step(1, 0, 3'd0, 32'h90, 0, 0, 0, 0, 0);
        repeat (3) step(1, 0, 3'd1, 32'h94, 1, 0, 0, 1, 0);
        step(0, 0, 3'd0, 32'h0,  0, 0, 0, 1, 0);
        step(1, 0, 3'd0, 32'h90, 0, 0, 0, 0, 0);
        // Flush on the entry edge: nothing in E afterwards.
        step(1, 0, 3'd0, 32'h98, 0, 1, 0, 1, 0);
        step(1, 0, 3'd0, 32'h98, 0, 0, 0, 1, 0);

        // Alternating outcomes on one PC: repeated mispredicts saturate the 2-bit counters.
        for (int i = 0; i < 8; i++)
            step(1, 0, 3'd0, 32'hA0, 0, 0, 0, 1'(i % 2), 0);

        // Reset with a branch in flight discards it.
        step(1, 0, 3'd0, 32'h40, 0, 0, 0, 1, 0);
        do_reset();
        step(1, 0, 3'd0, 32'h40, 0, 0, 0, 1, 0);

        // Randomized traffic with PC aliasing, stalls and flushes.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] pc;
            pc = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 5) << 2);
            step(bit'($urandom_range(0, 9) < 6), bit'($urandom_range(0, 9) == 0),
                 3'($urandom_range(0, 7)), pc,
                 bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 9) == 0),
                 1'($urandom), 1'($urandom), 1'($urandom));
            if (i == 300) do_reset();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
